// File: rtl/booth_mult_arb_pkg.sv
// Shared constants and types for the Booth multiplier sharing arbiter.
// The tag is sized for the largest supported requester count so one struct fits every build.
package booth_mult_arb_pkg;

   localparam int W_DEF       = 32;
   localparam int NREQ_DEF    = 4;
   localparam int NREQ_MAX    = 8;
   localparam int MUL_LAT_DEF = 2;
   localparam int TAG_W       = $clog2(NREQ_MAX);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
   } pipe_entry_t;

endpackage

// File: rtl/booth_mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr wins.
module rr_arbiter
   import booth_mult_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]  eligible,
   input  logic [TAG_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [TAG_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      // Outer loop walks the rotated priority order; inner loop maps each slot to a fixed index.
      for (int off = 0; off < NREQ; off++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && eligible[i] && (((int'(rr_ptr) + off) % NREQ) == i)) begin
               gnt[i]  = 1'b1;
               gnt_idx = TAG_W'(i);
               gnt_any = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/booth_mult_share_arbiter.sv
// Time-shares one fully pipelined signed multiplier among NREQ requesters; a tag travels with
// each issued operation so the product lands in the issuing requester's response register.
module booth_mult_share_arbiter
   import booth_mult_arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int W       = W_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [NREQ*2*W-1:0] rsp_result,
   output logic [NREQ-1:0]     rsp_overflow,
   input  logic [NREQ-1:0]     rsp_ready,
   output logic [W-1:0]        mul_a,
   output logic [W-1:0]        mul_b,
   input  logic [2*W-1:0]      mul_result,
   input  logic                mul_overflow,
   output logic                busy
);

   if (NREQ < 2 || NREQ > NREQ_MAX || MUL_LAT < 1) begin : g_bad_params
      $error("booth_mult_share_arbiter: unsupported NREQ or MUL_LAT");
   end

   logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NREQ-1:0]     outstanding_q, outstanding_d;
   pipe_entry_t         pipe_q [MUL_LAT];
   pipe_entry_t         pipe_d [MUL_LAT];
   logic signed [W-1:0] mul_a_q, mul_a_d;
   logic signed [W-1:0] mul_b_q, mul_b_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [NREQ*2*W-1:0] rsp_result_q, rsp_result_d;
   logic [NREQ-1:0]     rsp_ovf_q, rsp_ovf_d;

   logic [NREQ-1:0]     eligible;
   logic [NREQ-1:0]     gnt_w;
   logic [TAG_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic                rsp_clobber;

   assign eligible = rst ? '0 : (req & ~outstanding_q);

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .gnt      (gnt_w),
      .gnt_idx  (gnt_idx),
      .gnt_any  (gnt_any)
   );

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      outstanding_d = outstanding_q;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_ovf_d     = rsp_ovf_q;
      rsp_clobber   = 1'b0;

      pipe_d[0].valid = gnt_any;
      pipe_d[0].tag   = gnt_idx;
      for (int s = 1; s < MUL_LAT; s++) begin
         pipe_d[s] = pipe_q[s-1];
      end

      if (gnt_any) begin
         rr_ptr_d = (gnt_idx == TAG_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end

      // Grant, capture and handshake are independent per index; outstanding keeps them disjoint.
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_w[i]) begin
            mul_a_d          = req_a[i*W +: W];
            mul_b_d          = req_b[i*W +: W];
            outstanding_d[i] = 1'b1;
         end
         if (rsp_valid_q[i] && rsp_ready[i]) begin
            rsp_valid_d[i]   = 1'b0;
            outstanding_d[i] = 1'b0;
         end
         if (pipe_q[MUL_LAT-1].valid && (pipe_q[MUL_LAT-1].tag == TAG_W'(i))) begin
            rsp_clobber                  = rsp_valid_q[i] & ~rsp_ready[i];
            rsp_valid_d[i]               = 1'b1;
            rsp_result_d[i*2*W +: 2*W]   = mul_result;
            rsp_ovf_d[i]                 = mul_overflow;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         outstanding_q <= '0;
         for (int s = 0; s < MUL_LAT; s++) begin
            pipe_q[s] <= '0;
         end
         mul_a_q       <= '0;
         mul_b_q       <= '0;
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         rsp_ovf_q     <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         outstanding_q <= outstanding_d;
         for (int s = 0; s < MUL_LAT; s++) begin
            pipe_q[s] <= pipe_d[s];
         end
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_ovf_q     <= rsp_ovf_d;
      end
   end

   // A product arriving for a requester still holding an unconsumed result would be lost.
   assert property (@(posedge clk) disable iff (rst) !rsp_clobber);

   assign gnt          = gnt_w;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_overflow = rsp_ovf_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign busy         = |outstanding_q;

endmodule

// File: tb/tb_booth_mult_share_arbiter.sv
// Randomised and directed bench for booth_mult_share_arbiter with a behavioural scoreboard.
module tb_booth_mult_share_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 32;
   localparam int MUL_LAT = 2;

   typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; } op_t;
   typedef struct packed { logic [2*W-1:0] p; logic o; } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*W-1:0]   req_a, req_b;
   logic [NREQ-1:0]     gnt, rsp_valid, rsp_overflow, rsp_ready;
   logic [NREQ*2*W-1:0] rsp_result;
   logic [W-1:0]        mul_a, mul_b;
   logic [2*W-1:0]      mul_result;
   logic                mul_overflow;
   logic                busy;

   always #5 clk = ~clk;

   booth_mult_share_arbiter #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
      .rsp_ready(rsp_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .mul_overflow(mul_overflow), .busy(busy)
   );

   function automatic logic [2*W-1:0] mult_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] ea, eb;
      ea = $signed(a);
      eb = $signed(b);
      return ea * eb;
   endfunction

   // Overflow flag of the stand-in multiplier: product does not fit in W signed bits.
   function automatic logic ovf_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0]        p;
      logic signed [W-1:0]   lo;
      logic signed [2*W-1:0] ext;
      p   = mult_ref(a, b);
      lo  = p[W-1:0];
      ext = lo;
      return ext != p;
   endfunction

   // Stand-in for the external multiplier: one internal stage after the registered operands.
   always @(posedge clk) begin
      mul_result   <= mult_ref(mul_a, mul_b);
      mul_overflow <= ovf_ref(mul_a, mul_b);
   end

   int n_vec = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Requester-side stimulus and scoreboard state
   op_t             opq  [NREQ][$];
   exp_t            expq [NREQ][$];
   int              rdy_pct [NREQ];
   logic            rst_drv;
   logic [NREQ-1:0] m_out;
   int              m_ptr, cyc;
   int              m_arr [NREQ];
   int              gcount [NREQ], last_gnt [NREQ], rise [NREQ], hs_cyc [NREQ], hs_prev [NREQ];
   logic [2*W-1:0]  last_res [NREQ];
   logic            last_ovf [NREQ];
   logic [NREQ-1:0] prev_v;
   bit              armed = 1'b0;

   always @(negedge clk) begin : monitor
      logic [NREQ-1:0] eg;
      int              k;
      logic            ev;
      cyc++;
      if (armed) begin
         eg = '0;
         k  = -1;
         if (!rst) begin
            for (int off = 0; off < NREQ; off++) begin
               int j;
               j = (m_ptr + off) % NREQ;
               if (k < 0 && req[j] && !m_out[j]) k = j;
            end
         end
         if (k >= 0) eg[k] = 1'b1;
         chk("gnt", gnt, eg);
         chk("busy", busy, |m_out);
         for (int i = 0; i < NREQ; i++) begin
            ev = m_out[i] && (cyc >= m_arr[i]);
            chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], ev);
            if (ev && rsp_valid[i]) begin
               chk($sformatf("rsp_result[%0d]", i), rsp_result[i*2*W +: 2*W], expq[i][0].p);
               chk($sformatf("rsp_overflow[%0d]", i), rsp_overflow[i], expq[i][0].o);
            end
            if (rsp_valid[i] === 1'b1 && !prev_v[i]) rise[i] = cyc;
            if (ev && rsp_ready[i]) begin
               last_res[i] = rsp_result[i*2*W +: 2*W];
               last_ovf[i] = rsp_overflow[i];
               hs_prev[i]  = hs_cyc[i];
               hs_cyc[i]   = cyc;
               void'(expq[i].pop_front());
               m_out[i] = 1'b0;
            end
         end
         if (rst) begin
            m_out = '0;
            m_ptr = 0;
            for (int i = 0; i < NREQ; i++) expq[i].delete();
         end else if (k >= 0) begin
            m_out[k] = 1'b1;
            m_arr[k] = cyc + MUL_LAT + 1;
            expq[k].push_back({mult_ref(req_a[k*W +: W], req_b[k*W +: W]),
                               ovf_ref(req_a[k*W +: W], req_b[k*W +: W])});
            m_ptr = (k + 1) % NREQ;
         end
      end else if (rst) begin
         armed = 1'b1;
         m_out = '0;
         m_ptr = 0;
      end
      prev_v = rsp_valid;
      // A granted requester retires its operation
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i] === 1'b1) begin
            void'(opq[i].pop_front());
            gcount[i]++;
            last_gnt[i] = cyc;
         end
      end
   end

   task automatic apply();
      rst = rst_drv;
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (opq[i].size() != 0);
         if (req[i]) begin
            req_a[i*W +: W] = opq[i][0].a;
            req_b[i*W +: W] = opq[i][0].b;
         end
         rsp_ready[i] = ($urandom_range(99) < rdy_pct[i]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         apply();
      end
   endtask

   function automatic bit pending();
      bit p;
      p = (m_out != '0);
      for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_idle(input string nm, input int maxc);
      int n = 0;
      while (pending() && n < maxc) begin
         step(1);
         n++;
      end
      chk({nm, "_drained"}, pending(), 1'b0);
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      step(2);
      rst_drv = 1'b0;
      step(1);
   endtask

   task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      opq[i].push_back('{a: a, b: b});
   endtask

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(7))
         0:       return 32'h8000_0000;
         1:       return 32'h7fff_ffff;
         2:       return 32'hffff_ffff;
         3:       return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int g0, g1, old3;
      rst_drv = 1'b1;
      rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = '0;
      m_out = '0; m_ptr = 0; cyc = 0; prev_v = '0;
      for (int i = 0; i < NREQ; i++) begin
         rdy_pct[i] = 100; gcount[i] = 0; last_gnt[i] = 0; rise[i] = 0;
         hs_cyc[i] = 0; hs_prev[i] = 0; m_arr[i] = 0; last_res[i] = '0; last_ovf[i] = 1'b0;
      end
      step(3);
      rst_drv = 1'b0;
      step(1);
      chk("reset_rsp_result", rsp_result[2*W-1:0] | rsp_result[NREQ*2*W-1:2*W], '0);
      chk("reset_rsp_overflow", rsp_overflow, '0);
      chk("reset_mul_a", mul_a, '0);
      chk("reset_mul_b", mul_b, '0);

      // Single operation
      push(0, 32'd5, -32'sd7);
      wait_idle("t1", 40);
      chk("t1_latency", rise[0] - last_gnt[0], MUL_LAT + 1);
      chk("t1_result", last_res[0], -64'sd35);
      chk("t1_overflow", last_ovf[0], 1'b0);

      // Round-robin from pointer 0
      do_reset();
      push(0, 32'd2, 32'd3);
      push(1, -32'sd12, -32'sd4);
      push(2, -32'sd9, 32'd5);
      push(3, 32'd10, 32'd1);
      wait_idle("t2", 40);
      for (int i = 1; i < NREQ; i++)
         chk($sformatf("t2_order%0d", i), last_gnt[i] - last_gnt[i-1], 1);
      chk("t2_r0", last_res[0], 64'sd6);
      chk("t2_r1", last_res[1], 64'sd48);
      chk("t2_r2", last_res[2], -64'sd45);
      chk("t2_r3", last_res[3], 64'sd10);

      // Backpressure on requester 1 with a second request waiting
      rdy_pct[1] = 0;
      g1 = gcount[1];
      g0 = gcount[0];
      push(1, 32'd4, 32'd6);
      push(1, 32'd3, 32'd3);
      push(0, 32'd7, 32'd7);
      push(2, -32'sd1, 32'd100);
      step(12);
      push(0, 32'd8, -32'sd8);
      step(2);
      chk("t3_single_grant", gcount[1] - g1, 1);
      chk("t3_held_valid", rsp_valid[1], 1'b1);
      chk("t3_held_result", rsp_result[2*W +: 2*W], 64'sd24);
      chk("t3_others_served", gcount[0] - g0, 2);
      rdy_pct[1] = 100;
      wait_idle("t3", 40);
      chk("t3_second_result", last_res[1], 64'sd9);
      chk("t3_regrant_after_hs", last_gnt[1] - hs_prev[1], 1);

      // Reset the cycle after grants to 2 and 3
      do_reset();
      old3 = gcount[3];
      push(2, 32'd11, 32'd12);
      push(3, 32'd13, 32'd14);
      for (int n = 0; n < 20 && gcount[3] == old3; n++) step(1);
      chk("t4_grant3_seen", gcount[3] - old3, 1);
      rst_drv = 1'b1;
      step(1);
      rst_drv = 1'b0;
      step(5);
      chk("t4_busy", busy, 1'b0);
      chk("t4_no_rsp", rsp_valid, '0);
      push(1, 32'd2, 32'd2);
      push(0, 32'd3, 32'd3);
      wait_idle("t4a", 40);
      chk("t4_grant0_first", last_gnt[1] - last_gnt[0], 1);
      // Pointer would sit at 2 without the reset
      push(1, 32'd5, 32'd5);
      step(2);
      rst_drv = 1'b1;
      step(1);
      rst_drv = 1'b0;
      push(2, 32'd6, 32'd6);
      push(0, 32'd4, 32'd4);
      wait_idle("t4b", 40);
      chk("t4_ptr_cleared", last_gnt[2] - last_gnt[0], 1);

      // Boundary operands
      push(2, 32'hffff_ffff, -32'sd7);
      wait_idle("t5a", 40);
      chk("t5_neg_neg", last_res[2], 64'sd7);
      push(2, 32'd11, 32'd0);
      wait_idle("t5b", 40);
      chk("t5_zero", last_res[2], 64'd0);
      push(2, 32'h8000_0000, 32'h8000_0000);
      wait_idle("t5c", 40);
      chk("t5_min_min", last_res[2], 64'h4000_0000_0000_0000);
      chk("t5_min_min_ovf", last_ovf[2], 1'b1);

      // Random soak
      for (int i = 0; i < NREQ; i++) rdy_pct[i] = 60;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (opq[i].size() < 2 && $urandom_range(99) < 40) push(i, rand_opnd(), rand_opnd());
         rst_drv = ($urandom_range(2999) == 0);
         step(1);
      end
      rst_drv = 1'b0;
      for (int i = 0; i < NREQ; i++) rdy_pct[i] = 100;
      wait_idle("soak", 200);
      step(2);
      chk("soak_end_busy", busy, 1'b0);
      chk("soak_end_valid", rsp_valid, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
